// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and round-robin helper for the shared multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 4;

    // Upper bound on requesters the round-robin helper can search.
    localparam int MAX_REQ = 32;

    // First asserted valid bit searching upward from last+1, wrapping at n.
    // Returns last when nothing is valid; callers gate with |valid.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned n,
                                            input int unsigned last);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !found) begin
                // last < n and k <= n, so one subtraction wraps correctly.
                idx = last + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx[4:0]]) begin
                    pick  = idx;
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/shift_add_core.sv
// rtl/shift_add_core.sv - sequential shift-add unsigned multiplier datapath
module shift_add_core
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last_iter,
    output logic [2*WIDTH-1:0] product_next
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    // Next-state of the datapath: load operands, or add-then-shift one bit.
    always_comb begin
        m_d   = m_q;
        q_d   = q_q;
        acc_d = acc_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        sum   = {c_q, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
        if (load) begin
            m_d   = a;
            q_d   = b;
            acc_d = '0;
            c_d   = 1'b0;
            cnt_d = '0;
        end else if (step) begin
            // Shift {c,acc,Q} right by one using the post-add carry and acc.
            c_d   = 1'b0;
            acc_d = sum[WIDTH:1];
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign last_iter    = step && (cnt_q == CNT_W'(WIDTH - 1));
    assign product_next = {acc_d, q_d};

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q   <= '0;
            q_q   <= '0;
            acc_q <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            m_q   <= m_d;
            q_q   <= q_d;
            acc_q <= acc_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shared_mult_ctrl.sv
// rtl/shared_mult_ctrl.sv - round-robin controller sharing one shift-add multiplier
module shared_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_product,
    input  logic                   rsp_ready,
    output logic                   busy
);

    state_e               state_q, state_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;

    logic [MAX_REQ-1:0]   valid_ext;
    int unsigned          pick;
    logic [ID_W-1:0]      grant;
    logic                 accept;
    logic                 step;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   product_next;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;

    // Arbitration, FSM next-state and response register updates.
    always_comb begin
        valid_ext                = '0;
        valid_ext[N_REQ-1:0]     = req_valid;
        pick                     = rr_pick(valid_ext, N_REQ, 32'(last_q));
        grant                    = pick[ID_W-1:0];
        op_a                     = req_a[grant*WIDTH +: WIDTH];
        op_b                     = req_b[grant*WIDTH +: WIDTH];
        req_ready                = '0;
        accept                   = 1'b0;
        step                     = 1'b0;
        state_d                  = state_q;
        last_d                   = last_q;
        rsp_valid_d              = rsp_valid_q;
        rsp_id_d                 = rsp_id_q;
        rsp_product_d            = rsp_product_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    rsp_id_d         = grant;
                    last_d           = grant;
                    state_d          = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_iter) begin
                    rsp_product_d = product_next;
                    rsp_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    shift_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .load        (accept),
        .step        (step),
        .a           (op_a),
        .b           (op_b),
        .last_iter   (last_iter),
        .product_next(product_next)
    );

    // Controller state, round-robin pointer and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= ID_W'(N_REQ - 1);
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_shared_mult_ctrl.sv
// tb/tb_shared_mult_ctrl.sv - directed self-checking bench for shared_mult_ctrl
module tb_shared_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [1:0]  rv4 = '0;
    logic [7:0]  ra4 = '0;
    logic [7:0]  rb4 = '0;
    logic [1:0]  rr4;
    logic        vld4;
    logic [0:0]  id4;
    logic [7:0]  prod4;
    logic        rrdy4 = 1'b1;
    logic        busy4;

    logic [2:0]  rv8 = '0;
    logic [23:0] ra8 = '0;
    logic [23:0] rb8 = '0;
    logic [2:0]  rr8;
    logic        vld8;
    logic [1:0]  id8;
    logic [15:0] prod8;
    logic        rrdy8 = 1'b1;
    logic        busy8;

    int passed = 0;
    int total  = 0;
    int cyc;

    always #5 clk = ~clk;

    shared_mult_ctrl #(.WIDTH(4), .N_REQ(2)) dut4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_a(ra4), .req_b(rb4),
        .req_ready(rr4), .rsp_valid(vld4), .rsp_id(id4), .rsp_product(prod4),
        .rsp_ready(rrdy4), .busy(busy4)
    );

    shared_mult_ctrl #(.WIDTH(8), .N_REQ(3)) dut8 (
        .clk(clk), .rst(rst), .req_valid(rv8), .req_a(ra8), .req_b(rb8),
        .req_ready(rr8), .rsp_valid(vld8), .rsp_id(id8), .rsp_product(prod8),
        .rsp_ready(rrdy8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (vld4 !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (vld8 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // One full transaction on the 4-bit instance with rsp_ready held high.
    task automatic op4(input int idx, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input string tag);
        int n;
        rv4 = '0;
        rv4[idx] = 1'b1;
        ra4[idx*4 +: 4] = a;
        rb4[idx*4 +: 4] = b;
        rrdy4 = 1'b1;
        #1;
        check({tag, " req_ready"}, 32'(rr4), 32'(1 << idx));
        tick();
        rv4 = '0;
        wait4(n);
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " product"}, 32'(prod4), 32'(exp));
        check({tag, " id"}, 32'(id4), 32'(idx));
        tick();
        check({tag, " rsp_valid drop"}, 32'(vld4), 32'd0);
    endtask

    initial begin
        logic [0:0] exp_id;
        logic [7:0] exp_p;

        // Reset state of both instances.
        tick();
        tick();
        check("rst req_ready4", 32'(rr4), 32'd0);
        check("rst rsp_valid4", 32'(vld4), 32'd0);
        check("rst rsp_id4", 32'(id4), 32'd0);
        check("rst product4", 32'(prod4), 32'd0);
        check("rst busy4", 32'(busy4), 32'd0);
        check("rst busy8", 32'(busy8), 32'd0);
        check("rst product8", 32'(prod8), 32'd0);
        rst = 1'b0;
        tick();

        // Basic products, including carry out of the accumulator.
        op4(0, 4'd4, 4'd2, 8'd8, "4x2");
        op4(0, 4'd15, 4'd15, 8'd225, "15x15");
        op4(0, 4'd0, 4'd9, 8'd0, "0x9");

        // Fairness: fresh reset puts the pointer at 1, so 0 wins first.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        rv4 = 2'b11;
        ra4 = {4'd7, 4'd3};
        rb4 = {4'd6, 4'd5};
        rrdy4 = 1'b1;
        exp_id = 1'b0;
        for (int t = 0; t < 4; t++) begin
            exp_p = (exp_id == 1'b0) ? 8'd15 : 8'd42;
            #1;
            check("rr req_ready", 32'(rr4), (exp_id == 1'b0) ? 32'd1 : 32'd2);
            tick();
            wait4(cyc);
            check("rr id", 32'(id4), 32'(exp_id));
            check("rr product", 32'(prod4), 32'(exp_p));
            tick();
            exp_id = ~exp_id;
        end
        rv4 = 2'b00;
        tick();

        // Backpressure: response held while rsp_ready is low.
        rv4 = 2'b01;
        ra4 = {4'd2, 4'd5};
        rb4 = {4'd2, 4'd3};
        rrdy4 = 1'b0;
        #1;
        tick();
        rv4 = 2'b10;
        wait4(cyc);
        check("bp latency", 32'(cyc), 32'd4);
        for (int t = 0; t < 5; t++) begin
            tick();
            check("bp rsp_valid", 32'(vld4), 32'd1);
            check("bp product", 32'(prod4), 32'd15);
            check("bp id", 32'(id4), 32'd0);
            check("bp req_ready", 32'(rr4), 32'd0);
        end
        rrdy4 = 1'b1;
        tick();
        check("bp released valid", 32'(vld4), 32'd0);
        check("bp idle", 32'(busy4), 32'd0);
        check("bp next ready", 32'(rr4), 32'd2);
        tick();
        check("bp next accepted", 32'(busy4), 32'd1);
        rv4 = 2'b00;
        wait4(cyc);
        check("bp next latency", 32'(cyc), 32'd4);
        check("bp next product", 32'(prod4), 32'd4);
        check("bp next id", 32'(id4), 32'd1);
        tick();

        // Reset mid-RUN aborts without a response.
        rv4 = 2'b01;
        ra4 = {4'd0, 4'd7};
        rb4 = {4'd0, 4'd7};
        #1;
        tick();
        rv4 = 2'b00;
        tick();
        tick();
        check("abort running", 32'(busy4), 32'd1);
        rst = 1'b1;
        #1;
        check("abort async busy", 32'(busy4), 32'd0);
        check("abort async valid", 32'(vld4), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("abort no rsp", 32'(vld4), 32'd0);
        rv4 = 2'b11;
        ra4 = {4'd5, 4'd2};
        rb4 = {4'd5, 4'd3};
        #1;
        check("abort grant0", 32'(rr4), 32'd1);
        tick();
        rv4 = 2'b00;
        wait4(cyc);
        check("abort new latency", 32'(cyc), 32'd4);
        check("abort new product", 32'(prod4), 32'd6);
        check("abort new id", 32'(id4), 32'd0);
        tick();

        // Wide instance: 255x255 from requester 2.
        rv8 = 3'b100;
        ra8[23:16] = 8'd255;
        rb8[23:16] = 8'd255;
        rrdy8 = 1'b1;
        #1;
        check("w8 req_ready", 32'(rr8), 32'd4);
        tick();
        rv8 = 3'b000;
        wait8(cyc);
        check("w8 latency", 32'(cyc), 32'd8);
        check("w8 product", 32'(prod8), 32'd65025);
        check("w8 id", 32'(id8), 32'd2);
        tick();
        check("w8 drop", 32'(vld8), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shared_mult_ctrl.md
# shared_mult_ctrl

Round-robin controller that shares one sequential shift-add unsigned multiplier between `N_REQ` requesters. It arbitrates incoming operand requests, loads the winner's operands, sequences `WIDTH` add/shift iterations, and returns the product with the requester's ID over a valid/ready response port. It sits between the arithmetic clients and the multiplier datapath. Direct instantiation of the multiplier by individual clients is replaced by this block.

## Interface
Parameters:
- `WIDTH`, 4: operand width; the product is `2*WIDTH` bits.
- `N_REQ`, 2: number of requesters (≥2); `ID_W = $clog2(N_REQ)`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `N_REQ`  per-requester operand-valid.
- `req_a`  in  `N_REQ*WIDTH`  multiplicands; requester i uses slice `[i*WIDTH +: WIDTH]`.
- `req_b`  in  `N_REQ*WIDTH`  multipliers, same slicing.
- `req_ready`  out  `N_REQ`  one-hot or zero; high only for the granted requester while the block is in IDLE.
- `rsp_valid`  out  1  product available.
- `rsp_id`  out  `ID_W`  index of the requester that owns `rsp_product`.
- `rsp_product`  out  `2*WIDTH`  unsigned product.
- `rsp_ready`  in  1  consumer accepts the response.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values:
  - Outputs: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_product=0`, `busy=0`.
  - Internal: `M=0`, `Q=0`, `acc=0`, carry `c=0`, iteration count `cnt=0`, RR pointer `last=N_REQ-1`.
- **IDLE:**
  - The grant is the first asserted `req_valid` searching from `last+1` modulo `N_REQ`.
  - `req_ready[grant]=1` combinationally, and only in IDLE.
  - On the edge where `req_valid[g] && req_ready[g]`:
    - `M←req_a[g]`, `Q←req_b[g]`, `acc←0`, `c←0`, `cnt←0`.
    - `rsp_id←g`, `last←g`.
    - Next state RUN.
- **RUN** (one iteration per cycle):
  - If `Q[0]`, then `{c,acc} ← acc + M`, computed `WIDTH+1` bits wide.
  - Then `{c,acc,Q} ← {c,acc,Q} >> 1`, using the post-add values in the same cycle.
  - `cnt` increments each cycle.
  - After iteration `WIDTH-1`: `rsp_product ← {acc,Q}` (final values), `rsp_valid←1`, next state DONE.
- **DONE:**
  - `rsp_valid`, `rsp_id` and `rsp_product` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: `rsp_valid←0`, next state IDLE.
- Requests arriving during RUN or DONE are not accepted; the requester holds `req_valid` and its operands.
- The pointer only advances on acceptance, so a requester that drops `req_valid` before grant loses nothing.
- `rst` asserted in any state, including mid-RUN, aborts the operation immediately. No response is produced for the aborted request.

## Timing
- Acceptance on edge T0 → RUN iterations on edges T1..T`WIDTH` → `rsp_valid` high from T`WIDTH` (latency `WIDTH` cycles).
- With `rsp_ready` held high, the response handshake occurs on edge T`WIDTH+1`. IDLE is entered at that edge, and the next acceptance occurs no earlier than T`WIDTH+2`. Peak throughput is one product per `WIDTH+2` cycles.
- `req_ready` is a combinational function of state, `req_valid` and `last`. It has no path from `rsp_ready`.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0, …
- When a single requester is continuously valid, it receives every grant.

## Structure
- Shared package `mult_pkg`: state enum (IDLE, RUN, DONE), default `WIDTH`, and a function returning the round-robin pick from `(valid, last)`.
- Sub-module `shift_add_core`:
  - Holds `M`, `Q`, `acc`, `c` and `cnt`.
  - Inputs: `load`, `step`. Output: `last_iter`.
  - The controller FSM, arbiter and response registers stay in `shared_mult_ctrl`.

## Test plan
- Reset, then requester 0 sends A=4, B=2 with `rsp_ready=1` → `req_ready[0]` high in the request cycle; `rsp_valid` exactly 4 cycles after acceptance; `rsp_product=8`, `rsp_id=0`.
- A=15, B=15, then A=0, B=9 → `rsp_product=225` (exercises the carry), then `0`.
- Requesters 0 and 1 both valid continuously with different operands → grants alternate 0,1,0,1. Each response carries the matching ID and product, e.g. 3×5=15 for ID 0 and 7×6=42 for ID 1.
- Hold `rsp_ready=0` for 5 cycles after `rsp_valid` → outputs stable and `req_ready=0` throughout. Handshake on release, then acceptance of the next request one cycle later.
- Assert `rst` two cycles into RUN, release, then request 2×3 → no response for the aborted operation; the new response is `rsp_product=6` and the grant goes to requester 0 first.
- `WIDTH=8`, `N_REQ=3`, with 255×255 from requester 2 → `rsp_product=65025`, `rsp_id=2`, latency 8 cycles.
